// File: rtl/mult_pkg.sv
// Purpose: shared types and constants for the shift-add multiplier.
// Contents: operand/product/counter widths, FSM state enum, two's-complement
//           magnitude helper (used when MULT_SIGNED_EN is defined).
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned CNT_W      = 6;
  localparam int unsigned PROD_W     = 2 * MULT_WIDTH;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } mult_state_t;

  // Magnitude of a two's-complement operand; the most negative value maps to
  // 2^(W-1), which still fits as an unsigned W-bit number.
  function automatic logic [MULT_WIDTH-1:0] abs_val(input logic [MULT_WIDTH-1:0] v);
    return v[MULT_WIDTH-1] ? (~v + MULT_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_shift_add_32_bit_if.sv
// Purpose: request/result bundle between the multiplier and its client.
// Signals: start, X, Y (client -> multiplier); busy, done, P (multiplier -> client).
// Modports: master = client side, slave = multiplier side.
interface mult_shift_add_32_bit_if
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
);

  logic               start;
  logic [WIDTH-1:0]   X;
  logic [WIDTH-1:0]   Y;
  logic               busy;
  logic               done;
  logic [2*WIDTH-1:0] P;

  modport master (output start, output X, output Y, input busy, input done, input P);
  modport slave  (input start, input X, input Y, output busy, output done, output P);

endinterface

// File: rtl/add_rca_32_bit.sv
// Purpose: 32-bit ripple-carry adder used as the multiplier step adder.
// Ports: x_i, y_i (addends), ci_i (carry in), sum_o (sum), co_o (carry out).
module add_rca_32_bit (
  input  logic [31:0] x_i,
  input  logic [31:0] y_i,
  input  logic        ci_i,
  output logic [31:0] sum_o,
  output logic        co_o
);

  logic [31:0] sum_c;
  logic        carry_c;

  // Bit-serial carry chain, one full adder per bit.
  always_comb begin
    sum_c   = '0;
    carry_c = ci_i;
    for (int i = 0; i < 32; i++) begin
      sum_c[i] = x_i[i] ^ y_i[i] ^ carry_c;
      carry_c  = (x_i[i] & y_i[i]) | (carry_c & (x_i[i] ^ y_i[i]));
    end
  end

  assign sum_o = sum_c;
  assign co_o  = carry_c;

endmodule

// File: rtl/mult_shift_add_32_bit.sv
// Purpose: sequential 32x32 shift-add multiplier, one add/shift step per clock.
// Ports: clk, rst (async, active-high); bus (slave modport): start, X, Y in;
//        busy, done, P out. P = {A,Q} holds until the next accepted start.
// Configuration: define MULT_SIGNED_EN for two's-complement operands (adds a
//        FIX cycle that negates the product when the operand signs differ).
module mult_shift_add_32_bit
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  mult_shift_add_32_bit_if.slave   bus
);

  mult_state_t      state_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q;
  logic             done_q;
`ifdef MULT_SIGNED_EN
  logic             sign_q;
`endif

  logic [WIDTH-1:0] sum_c;
  logic             co_c;

  // Step adder: A + M, carry-in tied low.
  add_rca_32_bit u_add (
    .x_i   (a_q),
    .y_i   (m_q),
    .ci_i  (1'b0),
    .sum_o (sum_c),
    .co_o  (co_c)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      m_q     <= '0;
      a_q     <= '0;
      q_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef MULT_SIGNED_EN
      sign_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            state_q <= CALC;
            busy_q  <= 1'b1;
            a_q     <= '0;
            cnt_q   <= '0;
`ifdef MULT_SIGNED_EN
            m_q     <= abs_val(bus.X);
            q_q     <= abs_val(bus.Y);
            sign_q  <= bus.X[WIDTH-1] ^ bus.Y[WIDTH-1];
`else
            m_q     <= bus.X;
            q_q     <= bus.Y;
`endif
          end
        end
        CALC: begin
          // Carry-out of the step add shifts into the top of A.
          if (q_q[0]) begin
            {a_q, q_q} <= {co_c, sum_c, q_q[WIDTH-1:1]};
          end else begin
            {a_q, q_q} <= {1'b0, a_q, q_q[WIDTH-1:1]};
          end
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef MULT_SIGNED_EN
            state_q <= FIX;
`else
            state_q <= DONE;
            done_q  <= 1'b1;
`endif
          end
        end
`ifdef MULT_SIGNED_EN
        FIX: begin
          // Dedicated incrementer for the negation; the step adder stays single-use.
          if (sign_q) begin
            {a_q, q_q} <= ~{a_q, q_q} + (2 * WIDTH)'(1);
          end
          state_q <= DONE;
          done_q  <= 1'b1;
        end
`endif
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.P    = {a_q, q_q};

endmodule
